cube_arbiter: RTL

Shares one pipelined `cube` datapath (result = num³ mod 2^32, fixed latency, no valid/stall) among NUM_REQ requesters. Each request is a valid/ready handshake. A round-robin grant picks one operand per cycle, the issue is tagged with the requester index, and each result is retired into a response FIFO. Credit-based issue guarantees that no result leaving the non-stallable pipeline is ever dropped.

---
 rtl/cube_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/cube_arbiter.sv
// rtl/cube_arbiter.sv - round-robin, credit-gated sharing of one fixed-latency cube datapath
// Results retire in issue order into a response FIFO tagged with the requester index.
module cube_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int WIDTH      = 32,
  parameter int CUBE_LAT   = 5,
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = $clog2(NUM_REQ)
) (
  input  logic                             clock,
  input  logic                             reset_done,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]         req_num,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic [WIDTH-1:0]                 cube_num,
  input  logic [WIDTH-1:0]                 cube_result,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [TAG_W-1:0]                 rsp_tag,
  output logic [WIDTH-1:0]                 rsp_data,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  inflight
);

  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW:0]      CREDIT_MAX = (CW+1)'(FIFO_DEPTH);
  localparam logic [PW-1:0]    PTR_LAST   = PW'(FIFO_DEPTH-1);
  localparam logic [TAG_W-1:0] TAG_LAST   = TAG_W'(NUM_REQ-1);

  logic [TAG_W-1:0] rr_q, rr_d, grant, idx;
  logic             found, credit_ok, hs, push, pop;
  logic [WIDTH-1:0] cube_num_q, cube_num_d;
  logic             trk_vld_q [CUBE_LAT+1];
  logic             trk_vld_d [CUBE_LAT+1];
  logic [TAG_W-1:0] trk_tag_q [CUBE_LAT+1];
  logic [TAG_W-1:0] trk_tag_d [CUBE_LAT+1];
  logic [TAG_W-1:0] mem_tag_q [FIFO_DEPTH];
  logic [TAG_W-1:0] mem_tag_d [FIFO_DEPTH];
  logic [WIDTH-1:0] mem_data_q [FIFO_DEPTH];
  logic [WIDTH-1:0] mem_data_d [FIFO_DEPTH];
  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    count_q, count_d, inflight_q, inflight_d;

  // Credit counts both results still in the pipe and results parked in the FIFO.
  assign credit_ok = ({1'b0, inflight_q} + {1'b0, count_q}) < CREDIT_MAX;

  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = TAG_W'((int'(rr_q) + off) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
    hs = found && credit_ok && !reset_done;
  end

  always_comb begin
    req_ready  = '0;
    cube_num_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (hs && grant == TAG_W'(i)) begin
        req_ready[i] = 1'b1;
        cube_num_d   = req_num[i*WIDTH +: WIDTH];
      end
    end
    rr_d = rr_q;
    if (hs) rr_d = (grant == TAG_LAST) ? '0 : grant + TAG_W'(1);
  end

  // Stage 0 is loaded alongside cube_num, so the last of CUBE_LAT+1 stages
  // lines up with cube_result for that operand.
  always_comb begin
    trk_vld_d[0] = hs;
    trk_tag_d[0] = hs ? grant : '0;
    for (int j = 1; j <= CUBE_LAT; j++) begin
      trk_vld_d[j] = trk_vld_q[j-1];
      trk_tag_d[j] = trk_tag_q[j-1];
    end
  end

  assign push = trk_vld_q[CUBE_LAT];
  assign pop  = (count_q != '0) && rsp_ready;

  always_comb begin
    mem_tag_d  = mem_tag_q;
    mem_data_d = mem_data_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    count_d    = count_q;
    inflight_d = inflight_q;
    if (push) begin
      mem_tag_d[wr_q]  = trk_tag_q[CUBE_LAT];
      mem_data_d[wr_q] = cube_result;
      wr_d = (wr_q == PTR_LAST) ? '0 : wr_q + PW'(1);
    end
    if (pop) rd_d = (rd_q == PTR_LAST) ? '0 : rd_q + PW'(1);
    if (push && !pop) count_d = count_q + CW'(1);
    if (!push && pop) count_d = count_q - CW'(1);
    if (hs && !push) inflight_d = inflight_q + CW'(1);
    if (!hs && push) inflight_d = inflight_q - CW'(1);
  end

  always_ff @(posedge clock or posedge reset_done) begin
    if (reset_done) begin
      rr_q       <= '0;
      cube_num_q <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      for (int j = 0; j <= CUBE_LAT; j++) begin
        trk_vld_q[j] <= 1'b0;
        trk_tag_q[j] <= '0;
      end
      for (int k = 0; k < FIFO_DEPTH; k++) begin
        mem_tag_q[k]  <= '0;
        mem_data_q[k] <= '0;
      end
    end else begin
      rr_q       <= rr_d;
      cube_num_q <= cube_num_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      trk_vld_q  <= trk_vld_d;
      trk_tag_q  <= trk_tag_d;
      mem_tag_q  <= mem_tag_d;
      mem_data_q <= mem_data_d;
    end
  end

  assign cube_num  = cube_num_q;
  assign inflight  = inflight_q;
  assign rsp_valid = (count_q != '0);
  assign rsp_tag   = rsp_valid ? mem_tag_q[rd_q] : '0;
  assign rsp_data  = rsp_valid ? mem_data_q[rd_q] : '0;

endmodule
